// File: rtl/sad_match_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sad_match_engine
// Brief    : Sliding-window sum-of-absolute-differences pattern-match trigger.
//            Systolic accumulators compare the last cfg_len samples against a
//            stored reference on every valid sample; a registered compare
//            against the threshold drives a single-shot or auto-rearm trigger.
// Revision : 1.0 - initial release
// ============================================================================
module sad_match_engine #(
    parameter int DATA_WIDTH = 10,
    parameter int REF_LEN    = 128,
    parameter int SUM_WIDTH  = 20,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic                       ref_wr,
    input  logic [$clog2(REF_LEN)-1:0] ref_addr,
    input  logic [DATA_WIDTH-1:0]      ref_data,
    input  logic [$clog2(REF_LEN):0]   cfg_len,
    input  logic [SUM_WIDTH-1:0]       threshold,
    input  logic                       mode_rearm,
    input  logic [CNT_WIDTH-1:0]       holdoff,
    input  logic                       arm,
    input  logic [DATA_WIDTH-1:0]      adc_data,
    input  logic                       adc_valid,
    output logic [SUM_WIDTH-1:0]       sad_out,
    output logic                       sad_valid,
    output logic                       trig_out,
    output logic                       armed,
    output logic [CNT_WIDTH-1:0]       match_count
);

    localparam int c_AW = $clog2(REF_LEN);
    localparam int c_LW = c_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // |a-b| formed at DATA_WIDTH+1 signed, then zero-extended to the sum width
    function automatic logic [SUM_WIDTH-1:0] abs_diff(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d < 0) d = -d;
        return SUM_WIDTH'($unsigned(d));
    endfunction

    logic [DATA_WIDTH-1:0] r_ref     [REF_LEN];
    logic [SUM_WIDTH-1:0]  r_acc     [REF_LEN];
    logic [SUM_WIDTH-1:0]  w_acc_nxt [REF_LEN];

    logic [c_LW-1:0]      w_len;
    logic [c_AW-1:0]      w_last;
    logic [c_LW-1:0]      r_fill;
    logic [c_LW-1:0]      w_fill_inc;
    logic [c_LW-1:0]      r_len_q;
    logic                 r_arm_q;
    logic                 w_arm_rise;
    logic                 w_clear;
    logic                 r_tick;
    logic [SUM_WIDTH-1:0] r_sad;
    logic                 r_sad_valid;

    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_hold, w_hold_nxt;
    logic [CNT_WIDTH-1:0] r_count, w_count_nxt;
    logic                 r_trig, w_trig_nxt;
    logic                 w_hit;

    // Reference store: no reset, the register block loads it before use
    always_ff @(posedge clk) begin
        if (ref_wr) r_ref[ref_addr] <= ref_data;
    end

    // Effective window length: 0 behaves as 1, anything past REF_LEN clamps
    always_comb begin
        w_len = cfg_len;
        if (cfg_len == '0)
            w_len = c_LW'(1);
        else if (cfg_len > c_LW'(REF_LEN))
            w_len = c_LW'(REF_LEN);
    end

    assign w_last     = c_AW'(w_len - c_LW'(1));
    assign w_arm_rise = arm & ~r_arm_q;
    assign w_clear    = w_arm_rise | ref_wr | (cfg_len != r_len_q);
    assign w_fill_inc = (r_fill >= w_len) ? w_len : r_fill + c_LW'(1);

    // Next value of every systolic stage; ref[0] pairs with the oldest sample
    always_comb begin
        w_acc_nxt[0] = abs_diff(adc_data, r_ref[0]);
        for (int k = 1; k < REF_LEN; k++)
            w_acc_nxt[k] = r_acc[k-1] + abs_diff(adc_data, r_ref[k]);
    end

    // Datapath: accumulators, SAD output, fill tracking, edge/change detect
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < REF_LEN; k++) r_acc[k] <= '0;
            r_fill      <= '0;
            r_len_q     <= '0;
            r_arm_q     <= 1'b0;
            r_tick      <= 1'b0;
            r_sad       <= '0;
            r_sad_valid <= 1'b0;
        end else begin
            r_arm_q     <= arm;
            r_len_q     <= cfg_len;
            r_tick      <= adc_valid;
            r_sad_valid <= adc_valid & ~w_clear & (w_fill_inc == w_len);
            if (adc_valid) begin
                for (int k = 0; k < REF_LEN; k++) r_acc[k] <= w_acc_nxt[k];
                r_sad <= w_acc_nxt[w_last];
            end
            if (w_clear)
                r_fill <= '0;
            else if (adc_valid)
                r_fill <= w_fill_inc;
        end
    end

    assign w_hit = r_sad_valid && (r_sad < threshold);

    // Trigger FSM state and its registered outputs
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_count <= '0;
            r_trig  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_count <= w_count_nxt;
            r_trig  <= w_trig_nxt;
        end
    end

    // Next-state logic; an arm edge overrides everything, including a hit
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_count_nxt = r_count;
        w_trig_nxt  = 1'b0;
        if (w_arm_rise) begin
            w_state_nxt = ST_ARMED;
            w_hold_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_hit) begin
                        w_trig_nxt  = 1'b1;
                        w_count_nxt = (r_count == '1) ? r_count : r_count + CNT_WIDTH'(1);
                        if (!mode_rearm) begin
                            w_state_nxt = ST_IDLE;
                        end else if (holdoff != '0) begin
                            w_state_nxt = ST_HOLDOFF;
                            w_hold_nxt  = holdoff;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    // r_tick marks a sample accepted on the previous edge
                    if (r_tick) begin
                        if (r_hold <= CNT_WIDTH'(1)) begin
                            w_state_nxt = ST_ARMED;
                            w_hold_nxt  = '0;
                        end else begin
                            w_hold_nxt = r_hold - CNT_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sad_out     = r_sad;
    assign sad_valid   = r_sad_valid;
    assign trig_out    = r_trig;
    assign armed       = (r_state == ST_ARMED);
    assign match_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sad_match_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sad_match_engine
// Brief    : Self-checking bench for sad_match_engine (REF_LEN=8). A window
//            model built from sample history and index arithmetic predicts
//            every output; vector tables and directed sequences add
//            hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sad_match_engine;

    localparam int DW = 10;
    localparam int RL = 8;
    localparam int SW = 20;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          ref_wr;
    logic [2:0]    ref_addr;
    logic [DW-1:0] ref_data;
    logic [3:0]    cfg_len;
    logic [SW-1:0] threshold;
    logic          mode_rearm;
    logic [CW-1:0] holdoff;
    logic          arm;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic [SW-1:0] sad_out;
    logic          sad_valid;
    logic          trig_out;
    logic          armed;
    logic [CW-1:0] match_count;

    always #5 clk = ~clk;

    sad_match_engine #(
        .DATA_WIDTH(DW), .REF_LEN(RL), .SUM_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_i(reset_i), .ref_wr(ref_wr), .ref_addr(ref_addr),
        .ref_data(ref_data), .cfg_len(cfg_len), .threshold(threshold),
        .mode_rearm(mode_rearm), .holdoff(holdoff), .arm(arm),
        .adc_data(adc_data), .adc_valid(adc_valid), .sad_out(sad_out),
        .sad_valid(sad_valid), .trig_out(trig_out), .armed(armed),
        .match_count(match_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mref [RL];
    int hist [$];
    int m_fill, m_prev_len, m_rearm, m_cnt, m_n;
    bit m_prev_arm, m_armed;
    bit pend_sv;
    int pend_sad, pend_idx;

    typedef struct {
        bit a; bit v; int x; int len; int thr;
        bit sv; int sad; bit trig; bit armd; int cnt;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mk(bit a, bit v, int x, int len, int thr,
                                bit sv, int sad, bit trig, bit armd, int cnt);
        vec_t r;
        r.a = a; r.v = v; r.x = x; r.len = len; r.thr = thr;
        r.sv = sv; r.sad = sad; r.trig = trig; r.armd = armd; r.cnt = cnt;
        return r;
    endfunction

    function automatic int iabs(int d);
        return (d < 0) ? -d : d;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_fill = 0; m_prev_len = 0; m_rearm = 0; m_cnt = 0; m_n = 0;
        m_prev_arm = 0; m_armed = 0; pend_sv = 0; pend_sad = 0; pend_idx = 0;
    endtask

    // One clock: drive, let the edge pass, predict from the rules, compare
    task automatic step(input bit a, input bit v, input int x,
                        input bit wr, input int wa, input int wd);
        int eff;
        bit rise, clr, e_sv, e_trig, e_armed;
        int e_sad;
        @(negedge clk);
        arm = a; adc_valid = v; adc_data = x[DW-1:0];
        ref_wr = wr; ref_addr = wa[2:0]; ref_data = wd[DW-1:0];
        @(posedge clk);
        #1;
        eff  = (cfg_len == 0) ? 1 : ((int'(cfg_len) > RL) ? RL : int'(cfg_len));
        rise = a && !m_prev_arm;
        m_prev_arm = a;
        clr  = rise || wr || (int'(cfg_len) != m_prev_len);
        m_prev_len = int'(cfg_len);
        // Trigger decision on the result produced at the previous edge
        e_trig = 0;
        if (rise) begin
            m_armed = 1; m_rearm = 0; m_cnt = 0;
        end else if (pend_sv && m_armed && pend_idx >= m_rearm &&
                     pend_sad < int'(threshold)) begin
            e_trig = 1;
            if (m_cnt < 65535) m_cnt++;
            if (!mode_rearm) m_armed = 0;
            else m_rearm = pend_idx + int'(holdoff) + 1;
        end
        e_armed = m_armed && (m_n >= m_rearm);
        // Window result for the sample taken at this edge
        e_sv = 0; e_sad = 0;
        if (v) begin
            hist.push_back(x);
            if (hist.size() > RL) void'(hist.pop_front());
            if (clr) m_fill = 0;
            else if (m_fill < eff) m_fill++;
            e_sv = !clr && (m_fill == eff);
            if (e_sv)
                for (int j = 0; j < eff; j++)
                    e_sad += iabs(hist[hist.size() - eff + j] - mref[j]);
            pend_idx = m_n;
            m_n++;
        end else if (clr) begin
            m_fill = 0;
        end
        pend_sv = e_sv; pend_sad = e_sad;
        if (wr) mref[wa] = wd;
        check("sad_valid", sad_valid, e_sv);
        if (e_sv) check("sad_out", sad_out, e_sad);
        check("trig_out", trig_out, e_trig);
        check("armed", armed, e_armed);
        check("match_count", match_count, m_cnt);
    endtask

    task automatic load_ref();
        for (int k = 0; k < RL; k++) step(0, 0, 0, 1, k, 10 * k);
    endtask

    initial begin
        int pos, nsv, wa, wd, x, sat_last;
        bit a, v, wr;
        int trig_q [$];

        reset_i = 1; ref_wr = 0; ref_addr = 0; ref_data = 0; cfg_len = 8;
        threshold = 1; mode_rearm = 0; holdoff = 0; arm = 0; adc_data = 0;
        adc_valid = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sad_out", sad_out, 0);
        check("rst_sad_valid", sad_valid, 0);
        check("rst_trig", trig_out, 0);
        check("rst_armed", armed, 0);
        check("rst_count", match_count, 0);
        @(negedge clk);
        reset_i = 0;
        load_ref();

        // Vector table: exact match single-shot, then 4-sample window
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, 10 * i, 8, 1, i == 7, 0, 0, 1, 0));
        tbl.push_front(mk(1, 0, 0, 8, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 10 * i, 4, 1, i == 3, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 999, 4, 1, 1, 999, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4, 1, 1, 1049, 0, 0, 1));
        tbl.push_back(mk(0, 1, 10, 4, 1, 1, 1059, 0, 0, 1));
        tbl.push_back(mk(0, 1, 20, 4, 1, 1, 1029, 0, 0, 1));
        tbl.push_back(mk(0, 1, 30, 4, 1, 1, 0, 0, 0, 1));
        foreach (tbl[i]) begin
            cfg_len = 4'(tbl[i].len);
            threshold = SW'(tbl[i].thr);
            step(tbl[i].a, tbl[i].v, tbl[i].x, 0, 0, 0);
            check("tbl_sad_valid", sad_valid, tbl[i].sv);
            if (tbl[i].sv) check("tbl_sad_out", sad_out, tbl[i].sad);
            check("tbl_trig", trig_out, tbl[i].trig);
            check("tbl_armed", armed, tbl[i].armd);
            check("tbl_count", match_count, tbl[i].cnt);
        end

        // Strict threshold boundary with ref+1 stream (SAD = 8)
        cfg_len = 8;
        for (int t = 8; t <= 9; t++) begin
            threshold = SW'(t);
            step(1, 0, 0, 0, 0, 0);
            for (int i = 0; i < 8; i++) step(0, 1, 10 * i + 1, 0, 0, 0);
            check("thr_sad_out", sad_out, 8);
            step(0, 0, 0, 0, 0, 0);
            check("thr_trig", trig_out, (t == 9) ? 1 : 0);
        end

        // adc_valid gaps must not disturb the result
        threshold = 1;
        nsv = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 10 * i, 0, 0, 0);
            if (sad_valid) nsv++;
            step(0, 0, 0, 0, 0, 0);
            if (sad_valid) nsv++;
        end
        check("gap_sv_count", nsv, 1);
        check("gap_sad_out", sad_out, 0);
        check("gap_trig", trig_out, 1);

        // ref_wr mid-window restarts the fill
        nsv = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 10 * i, 0, 0, 0);
        step(0, 1, 40, 1, 3, 30);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 10 * i, 0, 0, 0);
            if (sad_valid) nsv++;
        end
        check("wr_no_early_sv", nsv, 0);
        step(0, 1, 70, 0, 0, 0);
        check("wr_sv_after_8", sad_valid, 1);
        check("wr_sad_out", sad_out, 0);

        // Auto-rearm with holdoff=3: every sample matches (len 1, ref[0]=0)
        cfg_len = 1; mode_rearm = 1; holdoff = 3;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 0, 0, 0, 0);
            if (trig_out) trig_q.push_back(i);
        end
        check("ho_trig_count", trig_q.size(), 5);
        for (int i = 1; i < trig_q.size(); i++) check("ho_gap", trig_q[i] - trig_q[i-1], 4);
        check("ho_match_count", match_count, 5);

        // Asynchronous reset while a trigger is pending
        cfg_len = 8; mode_rearm = 0; holdoff = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 10 * i, 0, 0, 0);
        #2 reset_i = 1;
        #1;
        check("arst_sad_out", sad_out, 0);
        check("arst_sad_valid", sad_valid, 0);
        check("arst_trig", trig_out, 0);
        check("arst_armed", armed, 0);
        check("arst_count", match_count, 0);
        @(posedge clk);
        @(negedge clk);
        reset_i = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check("arst_no_trig", trig_out, 0);
        end
        load_ref();

        // Randomized traffic against the model
        threshold = 30; pos = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) cfg_len = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 49) == 0) threshold = SW'($urandom_range(0, 60));
            if ($urandom_range(0, 99) == 0) mode_rearm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) holdoff = CW'($urandom_range(0, 4));
            a  = ($urandom_range(0, 39) == 0);
            wr = ($urandom_range(0, 33) == 0);
            wa = $urandom_range(0, 7);
            wd = 10 * wa + $urandom_range(0, 3);
            v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) x = $urandom_range(0, 1023);
            else x = 10 * pos + $urandom_range(0, 3);
            step(a, v, x, wr, wa, wd);
            if (v) pos = (pos + 1) % 8;
        end

        // match_count saturation: a trigger on every sample
        cfg_len = 1; threshold = 1; mode_rearm = 1; holdoff = 0;
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step(0, 1, 0, 0, 0, 0);
        sat_last = match_count;
        check("sat_count", sat_last, 65535);
        step(0, 1, 0, 0, 0, 0);
        check("sat_hold", match_count, 65535);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sad_match_engine.md
Name: sad_match_engine

Overview:
- Parametrised sum-of-absolute-differences (SAD) pattern-match trigger for the capture path.
- Compares a sliding window of the most recent `cfg_len` ADC samples against a stored reference waveform on every valid sample.
- Fully pipelined, one result per sample, no stalls.
- Sits between the ADC sample stream and the trigger mux. The register block drives reference loading, threshold and mode.

Parameters:
- DATA_WIDTH, 10, ADC/reference sample width, unsigned.
- REF_LEN, 128, maximum reference length in samples; power of two, ≥2.
- SUM_WIDTH, 20, accumulator/SAD width; must be ≥ DATA_WIDTH+log2(REF_LEN).
- CNT_WIDTH, 16, width of holdoff and match counters.

Ports:
- clk  in  1  single clock; ADC sample clock domain.
- reset_i  in  1  asynchronous, active-high reset.
- ref_wr  in  1  write strobe for reference memory.
- ref_addr  in  log2(REF_LEN)  reference index; 0 = oldest sample in the window.
- ref_data  in  DATA_WIDTH  reference sample value.
- cfg_len  in  log2(REF_LEN)+1  active window length, 1..REF_LEN; 0 is treated as 1.
- threshold  in  SUM_WIDTH  match when SAD < threshold (strict).
- mode_rearm  in  1  0 = single-shot; 1 = auto-rearm after holdoff.
- holdoff  in  CNT_WIDTH  valid samples ignored after each trigger in rearm mode.
- arm  in  1  rising-edge-detected; arms engine and clears fill count.
- adc_data  in  DATA_WIDTH  sample.
- adc_valid  in  1  sample qualifier.
- sad_out  out  SUM_WIDTH  latest window SAD.
- sad_valid  out  1  one-cycle pulse; sad_out updated and window full.
- trig_out  out  1  one-cycle trigger pulse.
- armed  out  1  engine armed and waiting.
- match_count  out  CNT_WIDTH  triggers since arm; saturates at all-ones.

Behaviour:
- Reset: all accumulators, fill counter, holdoff counter and match_count are 0. sad_out=0, sad_valid=0, trig_out=0, armed=0. State is IDLE. Reference memory contents are undefined after reset.
- Systolic accumulators acc[0..REF_LEN-1], updated only when adc_valid=1:
  - acc[0] <= |x-ref[0]|
  - acc[k] <= acc[k-1] + |x-ref[k]|
- The accumulator at index cfg_len-1, after cfg_len samples, holds the SAD of the last cfg_len samples against ref[0..cfg_len-1].
- Width rules: absolute difference is computed at DATA_WIDTH+1 signed, then zero-extended to SUM_WIDTH. Sums never overflow given the SUM_WIDTH rule.
- Latency:
  - Sample accepted at edge N → sad_out/sad_valid valid after edge N; sad_out takes the next value of acc[cfg_len-1].
  - trig_out is registered from the sad_out compare, so it asserts after edge N+1.
- Fill counter increments per valid sample and saturates at cfg_len. sad_valid is asserted only when fill has reached cfg_len, including the sample just accepted.
- Fill counter clears on:
  - reset
  - arm rising edge
  - any ref_wr
  - any change of cfg_len
- Compare is evaluated only on sad_valid cycles.
- FSM:
  - IDLE: armed=0. Arm rising edge → ARMED.
  - ARMED: armed=1. sad_valid && sad_out<threshold → trig_out pulse and match_count+1. Then:
    - mode_rearm=0 → IDLE
    - mode_rearm=1 and holdoff=0 → stay ARMED
    - mode_rearm=1 and holdoff≠0 → HOLDOFF
  - HOLDOFF: armed=0. Counts valid samples down from holdoff; reaching 0 → ARMED. Accumulators keep running; compares are suppressed.
- An arm rising edge in any state restarts ARMED, clears fill and match_count, and cancels holdoff.
- Simultaneous ref_wr and adc_valid: the write takes effect for the next sample; the current sample uses the old value. Fill clears.
- Gaps in adc_valid freeze all pipeline state; no outputs pulse.
- Reset mid-operation returns to IDLE immediately (asynchronous). No trig_out pulse is emitted on reset release.

Test Plan:
- REF_LEN=8, cfg_len=8, ref[k]=10k, threshold=1, stream 0,10,…,70 after arm → sad_valid on 8th sample with sad_out=0; trig_out one cycle later; match_count=1; state IDLE.
- Same setup, stream ref+1 → sad_out=8. threshold=8 → no trigger. threshold=9 → trigger.
- cfg_len=4, stream 0,10,20,30 → sad_valid on 4th sample, sad_out=0. A 5th sample of 999 followed by 0,10,20 → SAD=999 then 0 after 4 clean samples.
- mode_rearm=1, holdoff=3, continuous repeating matches → triggers separated by exactly 3 suppressed valid samples; match_count increments per trigger; saturates at 0xFFFF in a forced-count test.
- adc_valid toggling 1/0, and ref_wr issued mid-window → results identical to the gap-free case; fill restarts after ref_wr with no sad_valid until 8 new samples arrive.
- Assert reset_i asynchronously mid-window while ARMED → all outputs 0 and armed=0 within the same cycle; no trig_out on release.
